// File: rtl/secded_uart_rx_pkg.sv
// Shared definitions for the SECDED UART receiver: timing default, receiver
// states, extended Hamming (8,4) codeword layout and its encode/decode functions.
package secded_uart_rx_pkg;

  localparam int BIT_CYCLES_DEF = 434;

  // Codeword bit index = Hamming position - 1; p0 is the overall parity bit.
  localparam int C_P1 = 0;
  localparam int C_P2 = 1;
  localparam int C_D0 = 2;
  localparam int C_P4 = 3;
  localparam int C_D1 = 4;
  localparam int C_D2 = 5;
  localparam int C_D3 = 6;
  localparam int C_P0 = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic [3:0] data;
    logic       single_err;
    logic       double_err;
  } dec_t;

  function automatic logic [7:0] hamming_encode(input logic [3:0] d);
    logic [7:0] c;
    c       = '0;
    c[C_D0] = d[0];
    c[C_D1] = d[1];
    c[C_D2] = d[2];
    c[C_D3] = d[3];
    c[C_P1] = d[0] ^ d[1] ^ d[3];
    c[C_P2] = d[0] ^ d[2] ^ d[3];
    c[C_P4] = d[1] ^ d[2] ^ d[3];
    c[C_P0] = ^c[6:0];
    return c;
  endfunction

  function automatic dec_t hamming_decode(input logic [7:0] code);
    logic [7:0] c;
    logic [2:0] s;
    logic       p;
    dec_t       r;
    c    = code;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    p    = ^code;
    r    = '0;
    // Odd overall parity means one flipped bit; s=0 then points at p0 itself.
    if (p) begin
      r.single_err = 1'b1;
      if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
    end else if (s != 3'd0) begin
      r.double_err = 1'b1;
    end
    r.data = {c[C_D3], c[C_D2], c[C_D1], c[C_D0]};
    return r;
  endfunction

endpackage

// File: rtl/secded_uart_rx_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection,
// centre sampling of 8 data bits LSB first, stop-bit check.
module uart_rx
  import secded_uart_rx_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx_serial,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_line_prev;
  rx_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  logic          w_line;
  rx_state_e     w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_valid_nxt;
  logic          w_ferr_nxt;

  assign w_line = r_sync[1];

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_line_prev && !w_line) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = '0;
        end
      end
      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_line ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_line, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          if (w_line) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync      <= 2'b11;
      r_line_prev <= 1'b1;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx_serial};
      r_line_prev <= w_line;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_ferr      <= w_ferr_nxt;
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;

endmodule

// File: rtl/secded_uart_rx.sv
// Top level: UART byte receiver feeding a combinational SECDED (8,4) decoder,
// plus the matching combinational encoder for the transmit side.
module secded_uart_rx
  import secded_uart_rx_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  input  logic [3:0] enc_data_in,
  output logic [7:0] enc_code_out,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic [3:0] dec_data,
  output logic       single_error,
  output logic       double_error
);

  logic [7:0] w_rx_data;
  dec_t       w_dec;

  uart_rx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx_serial(rx_serial),
    .o_data     (w_rx_data),
    .o_valid    (rx_ready),
    .o_frame_err(frame_err)
  );

  assign w_dec        = hamming_decode(w_rx_data);
  assign rx_data      = w_rx_data;
  assign dec_data     = w_dec.data;
  assign single_error = w_dec.single_err;
  assign double_error = w_dec.double_err;
  assign enc_code_out = hamming_encode(enc_data_in);

endmodule

// File: tb/tb_secded_uart_rx.sv
// Scoreboard bench for secded_uart_rx: frames are driven bit by bit, expected
// receive events are queued, and a monitor checks each rx_ready/frame_err pulse.
module tb_secded_uart_rx;

  localparam int BC = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [3:0] enc_data_in = 4'h0;
  logic [7:0] enc_code_out;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic [3:0] dec_data;
  logic       single_error;
  logic       double_error;

  secded_uart_rx #(.BIT_CYCLES(BC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .enc_data_in (enc_data_in),
    .enc_code_out(enc_code_out),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .dec_data    (dec_data),
    .single_error(single_error),
    .double_error(double_error)
  );

  always #10 clk = ~clk;

  typedef struct {
    string      tag;
    bit         is_ferr;
    logic [7:0] data;
    logic [3:0] dec;
    logic       s_err;
    logic       d_err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_events = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_ev(input string tag, input bit is_ferr, input logic [7:0] data,
                           input logic [3:0] dec, input logic s_err, input logic d_err);
    exp_t e;
    e.tag = tag; e.is_ferr = is_ferr; e.data = data; e.dec = dec;
    e.s_err = s_err; e.d_err = d_err;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (rx_ready || frame_err)) begin
      n_events++;
      if (q.size() == 0) begin
        check(rx_ready ? "unexpected_rx_ready" : "unexpected_frame_err", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, ".frame_err"},    frame_err,    e.is_ferr);
        check({e.tag, ".rx_ready"},     rx_ready,     !e.is_ferr);
        check({e.tag, ".rx_data"},      rx_data,      e.data);
        check({e.tag, ".dec_data"},     dec_data,     e.dec);
        check({e.tag, ".single_error"}, single_error, e.s_err);
        check({e.tag, ".double_error"}, double_error, e.d_err);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first and stop; flagged data bits are
  // inverted over the middle half of their bit time only.
  task automatic send_frame(input logic [7:0] b, input logic [7:0] flip, input logic stop_lvl);
    logic [9:0] bits;
    logic       lvl;
    bits = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BC; c++) begin
        lvl = bits[i];
        if (i >= 1 && i <= 8 && flip[i-1] && c >= BC / 4 && c < 3 * BC / 4) lvl = ~lvl;
        @(negedge clk);
        rx_serial = lvl;
      end
    end
    @(negedge clk);
    rx_serial = 1'b1;
  endtask

  initial begin
    logic [3:0] enc_in  [4];
    logic [7:0] enc_exp [4];
    enc_in  = '{4'h0, 4'h1, 4'h3, 4'hF};
    enc_exp = '{8'h00, 8'h87, 8'h1E, 8'hFF};

    idle(5);
    check("reset.rx_data",      rx_data,      32'h00);
    check("reset.rx_ready",     rx_ready,     32'h0);
    check("reset.frame_err",    frame_err,    32'h0);
    check("reset.dec_data",     dec_data,     32'h0);
    check("reset.single_error", single_error, 32'h0);
    check("reset.double_error", double_error, 32'h0);
    rst_n = 1'b1;
    idle(10);

    for (int i = 0; i < 4; i++) begin
      enc_data_in = enc_in[i];
      #1;
      check($sformatf("enc_%0h", enc_in[i]), enc_code_out, enc_exp[i]);
      @(negedge clk);
    end

    expect_ev("clean_87", 1'b0, 8'h87, 4'h1, 1'b0, 1'b0);
    send_frame(8'h87, 8'h00, 1'b1);
    expect_ev("clean_1E", 1'b0, 8'h1E, 4'h3, 1'b0, 1'b0);
    send_frame(8'h1E, 8'h00, 1'b1);
    expect_ev("clean_FF", 1'b0, 8'hFF, 4'hF, 1'b0, 1'b0);
    send_frame(8'hFF, 8'h00, 1'b1);

    expect_ev("single", 1'b0, 8'h85, 4'h1, 1'b1, 1'b0);
    send_frame(8'h87, 8'h02, 1'b1);
    expect_ev("double", 1'b0, 8'hA5, 4'h5, 1'b0, 1'b1);
    send_frame(8'h87, 8'h22, 1'b1);
    expect_ev("parity", 1'b0, 8'h07, 4'h1, 1'b1, 1'b0);
    send_frame(8'h07, 8'h00, 1'b1);

    // Short low pulse: must be rejected as a glitch.
    rx_serial = 1'b0;
    idle(BC / 4);
    rx_serial = 1'b1;
    idle(2 * BC);

    // Stop bit low: frame_err with rx_data still holding the last good byte.
    expect_ev("frame_err", 1'b1, 8'h07, 4'h1, 1'b1, 1'b0);
    send_frame(8'h55, 8'h00, 1'b0);
    idle(BC);

    // Reset in the middle of a frame.
    rx_serial = 1'b0;
    idle(2 * BC);
    rst_n = 1'b0;
    idle(4);
    rx_serial = 1'b1;
    rst_n = 1'b1;
    idle(2);
    check("midreset.rx_data",  rx_data,  32'h00);
    check("midreset.dec_data", dec_data, 32'h0);
    idle(10 * BC);

    expect_ev("after_reset", 1'b0, 8'h1E, 4'h3, 1'b0, 1'b0);
    send_frame(8'h1E, 8'h00, 1'b1);
    idle(BC);

    check("queue_drained", q.size(), 32'd0);
    check("event_count",   n_events, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/secded_uart_rx.md
# secded_uart_rx

Receive-side link block: deserializes 8N1 UART frames from a serial line, then SECDED-decodes each received byte as an extended Hamming (8,4) codeword into a 4-bit nibble with single-error correction and double-error detection. It also exposes the matching combinational (8,4) encoder, so the transmit side produces codewords of the identical layout. It sits between the serial pin and the nibble-level consumer.

## Interface
- BIT_CYCLES, 434: clock cycles per UART bit (50 MHz / 115200).
- clk  in  1  single system clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx_serial  in  1  asynchronous serial line, idle high.
- enc_data_in  in  4  nibble to encode.
- enc_code_out  out  8  combinational codeword of enc_data_in.
- rx_data  out  8  last received raw byte.
- rx_ready  out  1  one-cycle pulse: new rx_data and decode results valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- dec_data  out  4  corrected nibble decoded from rx_data.
- single_error  out  1  single-bit error detected and corrected.
- double_error  out  1  uncorrectable double-bit error.

## Operation
- Codeword layout (bit index = Hamming position − 1): c0=p1, c1=p2, c2=d0, c3=p4, c4=d1, c5=d2, c6=d3, c7=p0.
- Encoding: p1=d0^d1^d3; p2=d0^d2^d3; p4=d1^d2^d3; p0 = XOR of c6..c0 (even overall parity).
- Syndrome: s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s4=c3^c4^c5^c6; s={s4,s2,s1}; P = XOR of all 8 bits.
- Decode rules:
  - s=0, P=0: no error; flags 0.
  - P=1: single_error=1. If s≠0, flip bit s−1 before extracting data; if s=0, p0 itself is in error and data is unchanged.
  - s≠0, P=0: double_error=1, single_error=0; dec_data = uncorrected c6,c5,c4,c2.
- dec_data = {c6,c5,c4,c2} after correction.
- Decode is combinational from the rx_data register.
- Receiver FSM: IDLE, START, DATA, STOP.
  - IDLE → START on a high-to-low transition of the synchronized line.
  - START: wait BIT_CYCLES/2, re-sample. Line high means glitch, return to IDLE. Line low: go to DATA.
  - DATA: sample 8 bits, LSB first, each BIT_CYCLES apart (bit centres).
  - STOP: sample after BIT_CYCLES. Line high: load rx_data and pulse rx_ready. Line low: pulse frame_err and leave rx_data unchanged. Either way, return to IDLE.
- rx_data holds until the next good frame.

## Timing
- rx_serial passes through a 2-flop synchronizer; this adds 2 cycles of latency.
- rx_ready asserts about 9.5×BIT_CYCLES + 3 cycles after the start-bit falling edge, i.e. mid stop bit, before the transmitter's stop bit ends.
- The FSM re-arms in IDLE immediately after the stop-bit sample, so back-to-back frames with one stop bit are accepted.
- Reset values: rx_data=0x00, rx_ready=0, frame_err=0, FSM in IDLE, bit and cycle counters 0. dec_data=0 and both flags 0 follow from rx_data=0.
- Reset mid-frame aborts the frame: no rx_ready, rx_data cleared.
- enc_code_out: zero latency.

## Structure
- Shared package holds:
  - BIT_CYCLES default.
  - Codeword bit-position constants.
  - Pure functions: hamming_encode (4→8) and hamming_decode (8 → {data, single, double}).
- One sub-module, uart_rx (synchronizer + FSM + shift register).
- Top level = uart_rx + package decode + package encode.

## Test plan
- Encoder: enc_data_in 0x0/0x1/0x3/0xF → enc_code_out 0x00/0x87/0x1E/0xFF.
- Clean frames: send 0x87, 0x1E, 0xFF at BIT_CYCLES=434.
  - Each gives rx_ready, rx_data equal to the sent byte, dec_data 1/3/F, flags 0.
- Single error: send 0x87 with the line inverted across data bit 1 only (2.25–2.75 bit times).
  - rx_data=0x85, dec_data=0x1, single_error=1, double_error=0.
- Double error: send 0x87 with data bits 1 and 5 inverted.
  - rx_data=0xA5, double_error=1, single_error=0.
- Parity-bit error: receive 0x07 (p0 flipped) → dec_data=0x1, single_error=1.
- Robustness:
  - A low pulse shorter than BIT_CYCLES/2 gives no rx_ready.
  - A stop bit held low gives a frame_err pulse and leaves rx_data unchanged.
  - rst_n low mid-frame gives no rx_ready and rx_data=0x00; the next clean frame is received correctly.
